// File: rtl/conflict_manager_pkg.sv
// Shared widths, conflict_type bit positions and the batch-slot record
// used by the conflict manager and its dependency reducer.
package conflict_manager_pkg;

    localparam int unsigned DEP_W      = 256;
    localparam int unsigned BATCH_ID_W = 4;
    localparam int unsigned OWNER_W    = 64;

    localparam int unsigned CT_RAW = 2;
    localparam int unsigned CT_WAW = 1;
    localparam int unsigned CT_WAR = 0;

    // Sets are held at DEP_W; narrower instances zero-extend on write.
    typedef struct packed {
        logic               valid;
        logic [DEP_W-1:0]   read_deps;
        logic [DEP_W-1:0]   write_deps;
        logic [OWNER_W-1:0] owner;
    } slot_t;

endpackage

// File: rtl/conflict_manager_dep_union_reduce.sv
// ORs the read/write sets of all valid slots, optionally skipping slots
// whose owner matches the supplied owner ID.
module dep_union_reduce
    import conflict_manager_pkg::*;
#(
    parameter int unsigned N_SLOTS = 16
) (
    input  slot_t              slots [N_SLOTS],
    input  logic               mask_en,
    input  logic [OWNER_W-1:0] owner,
    output logic [DEP_W-1:0]   read_union,
    output logic [DEP_W-1:0]   write_union
);

    always_comb begin
        read_union  = '0;
        write_union = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (slots[i].valid && !(mask_en && (slots[i].owner == owner))) begin
                read_union  = read_union  | slots[i].read_deps;
                write_union = write_union | slots[i].write_deps;
            end
        end
    end

endmodule

// File: rtl/conflict_manager.sv
// Tracks active batch read/write sets and flags RAW/WAW/WAR hazards of a
// candidate transaction against batches owned by other programs.
module conflict_manager
    import conflict_manager_pkg::*;
#(
    parameter int unsigned MAX_DEPENDENCIES = 256,
    parameter int unsigned MAX_BATCHES      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        txn_valid,
    input  logic [MAX_DEPENDENCIES-1:0] txn_read_deps,
    input  logic [MAX_DEPENDENCIES-1:0] txn_write_deps,
    input  logic [63:0]                 txn_owner_id,
    output logic                        has_conflict,
    output logic [2:0]                  conflict_type,
    input  logic                        new_batch_valid,
    input  logic [3:0]                  new_batch_id,
    input  logic [MAX_DEPENDENCIES-1:0] new_batch_read_deps,
    input  logic [MAX_DEPENDENCIES-1:0] new_batch_write_deps,
    input  logic [63:0]                 new_batch_owner_id,
    input  logic                        batch_completed,
    input  logic [3:0]                  batch_id,
    output logic [MAX_DEPENDENCIES-1:0] global_read_dependencies,
    output logic [MAX_DEPENDENCIES-1:0] global_write_dependencies,
    output logic [31:0]                 global_conflicts,
    output logic [31:0]                 raw_conflict_count,
    output logic [31:0]                 waw_conflict_count,
    output logic [31:0]                 war_conflict_count
);

    slot_t       slots_q [MAX_BATCHES];
    slot_t       slots_d [MAX_BATCHES];
    logic [31:0] global_conflicts_q, global_conflicts_d;
    logic [31:0] raw_count_q, raw_count_d;
    logic [31:0] waw_count_q, waw_count_d;
    logic [31:0] war_count_q, war_count_d;

    logic [DEP_W-1:0] all_read, all_write;
    logic [DEP_W-1:0] other_read, other_write;
    logic [MAX_DEPENDENCIES-1:0] other_r, other_w;

    dep_union_reduce #(.N_SLOTS(MAX_BATCHES)) u_global_union (
        .slots       (slots_q),
        .mask_en     (1'b0),
        .owner       ('0),
        .read_union  (all_read),
        .write_union (all_write)
    );

    dep_union_reduce #(.N_SLOTS(MAX_BATCHES)) u_foreign_union (
        .slots       (slots_q),
        .mask_en     (1'b1),
        .owner       (txn_owner_id),
        .read_union  (other_read),
        .write_union (other_write)
    );

    assign global_read_dependencies  = all_read[MAX_DEPENDENCIES-1:0];
    assign global_write_dependencies = all_write[MAX_DEPENDENCIES-1:0];
    assign other_r = other_read[MAX_DEPENDENCIES-1:0];
    assign other_w = other_write[MAX_DEPENDENCIES-1:0];

    always_comb begin
        conflict_type = '0;
        if (txn_valid) begin
            conflict_type[CT_RAW] = |(txn_read_deps  & other_w);
            conflict_type[CT_WAW] = |(txn_write_deps & other_w);
            conflict_type[CT_WAR] = |(txn_write_deps & other_r);
        end
        has_conflict = |conflict_type;
    end

    // Completion is applied first so a same-slot registration overrides it.
    always_comb begin
        for (int unsigned i = 0; i < MAX_BATCHES; i++) begin
            slots_d[i] = slots_q[i];
        end
        if (batch_completed && (32'(batch_id) < MAX_BATCHES)) begin
            slots_d[batch_id].valid = 1'b0;
        end
        if (new_batch_valid && (32'(new_batch_id) < MAX_BATCHES)) begin
            slots_d[new_batch_id].valid      = 1'b1;
            slots_d[new_batch_id].read_deps  = DEP_W'(new_batch_read_deps);
            slots_d[new_batch_id].write_deps = DEP_W'(new_batch_write_deps);
            slots_d[new_batch_id].owner      = new_batch_owner_id;
        end
    end

    always_comb begin
        global_conflicts_d = global_conflicts_q;
        raw_count_d        = raw_count_q;
        waw_count_d        = waw_count_q;
        war_count_d        = war_count_q;
        if (has_conflict) begin
            global_conflicts_d = global_conflicts_q + 32'd1;
            raw_count_d        = raw_count_q + 32'(conflict_type[CT_RAW]);
            waw_count_d        = waw_count_q + 32'(conflict_type[CT_WAW]);
            war_count_d        = war_count_q + 32'(conflict_type[CT_WAR]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MAX_BATCHES; i++) begin
                slots_q[i] <= '0;
            end
            global_conflicts_q <= '0;
            raw_count_q        <= '0;
            waw_count_q        <= '0;
            war_count_q        <= '0;
        end else begin
            for (int unsigned i = 0; i < MAX_BATCHES; i++) begin
                slots_q[i] <= slots_d[i];
            end
            global_conflicts_q <= global_conflicts_d;
            raw_count_q        <= raw_count_d;
            waw_count_q        <= waw_count_d;
            war_count_q        <= war_count_d;
        end
    end

    assign global_conflicts   = global_conflicts_q;
    assign raw_conflict_count = raw_count_q;
    assign waw_conflict_count = waw_count_q;
    assign war_conflict_count = war_count_q;

endmodule

// File: tb/tb_conflict_manager.sv
// Self-checking bench for conflict_manager: directed scenarios plus a
// randomized run against a slot-table reference model.
module tb_conflict_manager;

    localparam int D = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          txn_valid;
    logic [D-1:0]  txn_read_deps, txn_write_deps;
    logic [63:0]   txn_owner_id;
    logic          has_conflict;
    logic [2:0]    conflict_type;
    logic          new_batch_valid;
    logic [3:0]    new_batch_id;
    logic [D-1:0]  new_batch_read_deps, new_batch_write_deps;
    logic [63:0]   new_batch_owner_id;
    logic          batch_completed;
    logic [3:0]    batch_id;
    logic [D-1:0]  global_read_dependencies, global_write_dependencies;
    logic [31:0]   global_conflicts, raw_conflict_count, waw_conflict_count, war_conflict_count;

    int checks = 0;
    int failures = 0;

    // Reference model: a plain table of batches plus event counters.
    logic          m_valid [16];
    logic [D-1:0]  m_rd [16];
    logic [D-1:0]  m_wr [16];
    logic [63:0]   m_own [16];
    logic [31:0]   m_gc, m_raw, m_waw, m_war;

    conflict_manager #(.MAX_DEPENDENCIES(256), .MAX_BATCHES(16)) dut (
        .clk(clk), .rst(rst),
        .txn_valid(txn_valid), .txn_read_deps(txn_read_deps),
        .txn_write_deps(txn_write_deps), .txn_owner_id(txn_owner_id),
        .has_conflict(has_conflict), .conflict_type(conflict_type),
        .new_batch_valid(new_batch_valid), .new_batch_id(new_batch_id),
        .new_batch_read_deps(new_batch_read_deps),
        .new_batch_write_deps(new_batch_write_deps),
        .new_batch_owner_id(new_batch_owner_id),
        .batch_completed(batch_completed), .batch_id(batch_id),
        .global_read_dependencies(global_read_dependencies),
        .global_write_dependencies(global_write_dependencies),
        .global_conflicts(global_conflicts),
        .raw_conflict_count(raw_conflict_count),
        .waw_conflict_count(waw_conflict_count),
        .war_conflict_count(war_conflict_count)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_type();
        logic [D-1:0] r = '0;
        logic [D-1:0] w = '0;
        if (!txn_valid) return 3'b000;
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i] && m_own[i] != txn_owner_id) begin
                r = r | m_rd[i];
                w = w | m_wr[i];
            end
        end
        return {|(txn_read_deps & w), |(txn_write_deps & w), |(txn_write_deps & r)};
    endfunction

    function automatic logic [D-1:0] exp_grd();
        logic [D-1:0] r = '0;
        for (int i = 0; i < 16; i++) if (m_valid[i]) r = r | m_rd[i];
        return r;
    endfunction

    function automatic logic [D-1:0] exp_gwr();
        logic [D-1:0] w = '0;
        for (int i = 0; i < 16; i++) if (m_valid[i]) w = w | m_wr[i];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_rd[i] = '0; m_wr[i] = '0; m_own[i] = '0;
        end
        m_gc = '0; m_raw = '0; m_waw = '0; m_war = '0;
    endtask

    // Applies one clock edge's worth of effects to the model, then clocks the DUT.
    task automatic edge_step();
        logic [2:0] t;
        t = exp_type();
        if (t != 3'b000) begin
            m_gc = m_gc + 1;
            if (t[2]) m_raw = m_raw + 1;
            if (t[1]) m_waw = m_waw + 1;
            if (t[0]) m_war = m_war + 1;
        end
        if (batch_completed) m_valid[batch_id] = 1'b0;
        if (new_batch_valid) begin
            m_valid[new_batch_id] = 1'b1;
            m_rd[new_batch_id]    = new_batch_read_deps;
            m_wr[new_batch_id]    = new_batch_write_deps;
            m_own[new_batch_id]   = new_batch_owner_id;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        txn_valid = 0; txn_read_deps = '0; txn_write_deps = '0; txn_owner_id = '0;
        new_batch_valid = 0; new_batch_id = '0; new_batch_read_deps = '0;
        new_batch_write_deps = '0; new_batch_owner_id = '0;
        batch_completed = 0; batch_id = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        txn_valid = 1; txn_read_deps = 256'h1; txn_write_deps = 256'h2; txn_owner_id = 64'd1;
        #1;
        checks++; if (has_conflict !== 1'b0) begin failures++; $display("FAIL reset_has_conflict got=%b exp=0", has_conflict); end
        checks++; if (conflict_type !== 3'b000) begin failures++; $display("FAIL reset_conflict_type got=%b exp=000", conflict_type); end
        checks++; if ({global_conflicts, raw_conflict_count, waw_conflict_count, war_conflict_count} !== 128'd0) begin
            failures++; $display("FAIL reset_counters got=%h/%h/%h/%h exp=0", global_conflicts, raw_conflict_count, waw_conflict_count, war_conflict_count); end
        checks++; if ((global_read_dependencies | global_write_dependencies) !== '0) begin
            failures++; $display("FAIL reset_global_deps got=%h/%h exp=0", global_read_dependencies, global_write_dependencies); end
        txn_valid = 0;
    endtask

    task automatic test_raw();
        new_batch_valid = 1; new_batch_id = 4'd3; new_batch_read_deps = 256'h0F;
        new_batch_write_deps = 256'hF0; new_batch_owner_id = 64'd5;
        txn_valid = 1; txn_read_deps = 256'h10; txn_write_deps = '0; txn_owner_id = 64'd9;
        #1;
        checks++; if (has_conflict !== 1'b0) begin failures++; $display("FAIL same_cycle_registration got=%b exp=0", has_conflict); end
        edge_step();
        new_batch_valid = 0;
        #1;
        checks++; if (conflict_type !== 3'b100) begin failures++; $display("FAIL raw_type got=%b exp=100", conflict_type); end
        checks++; if (has_conflict !== 1'b1) begin failures++; $display("FAIL raw_has_conflict got=%b exp=1", has_conflict); end
        edge_step();
        checks++; if (global_conflicts !== 32'd1) begin failures++; $display("FAIL raw_global_count got=%0d exp=1", global_conflicts); end
        checks++; if (raw_conflict_count !== 32'd1) begin failures++; $display("FAIL raw_count got=%0d exp=1", raw_conflict_count); end
    endtask

    task automatic test_all_types();
        logic [31:0] r0, w0, a0;
        r0 = raw_conflict_count; w0 = waw_conflict_count; a0 = war_conflict_count;
        txn_write_deps = 256'h11;
        #1;
        checks++; if (conflict_type !== 3'b111) begin failures++; $display("FAIL all_types_type got=%b exp=111", conflict_type); end
        edge_step();
        checks++; if (raw_conflict_count !== r0 + 1) begin failures++; $display("FAIL all_types_raw got=%0d exp=%0d", raw_conflict_count, r0 + 1); end
        checks++; if (waw_conflict_count !== w0 + 1) begin failures++; $display("FAIL all_types_waw got=%0d exp=%0d", waw_conflict_count, w0 + 1); end
        checks++; if (war_conflict_count !== a0 + 1) begin failures++; $display("FAIL all_types_war got=%0d exp=%0d", war_conflict_count, a0 + 1); end
        checks++; if (global_conflicts !== m_gc) begin failures++; $display("FAIL all_types_global got=%0d exp=%0d", global_conflicts, m_gc); end
    endtask

    task automatic test_owner_exclusion();
        txn_owner_id = 64'd5; txn_read_deps = 256'h10; txn_write_deps = '0;
        #1;
        checks++; if (has_conflict !== 1'b0) begin failures++; $display("FAIL owner_excl_has_conflict got=%b exp=0", has_conflict); end
        checks++; if (global_write_dependencies !== 256'hF0) begin failures++; $display("FAIL owner_excl_gwr got=%h exp=f0", global_write_dependencies); end
        txn_valid = 0;
    endtask

    task automatic test_same_slot();
        batch_completed = 1; batch_id = 4'd3;
        new_batch_valid = 1; new_batch_id = 4'd3; new_batch_read_deps = '0;
        new_batch_write_deps = 256'h100; new_batch_owner_id = 64'd7;
        edge_step();
        drive_idle();
        checks++; if (global_write_dependencies !== 256'h100) begin failures++; $display("FAIL same_slot_gwr got=%h exp=100", global_write_dependencies); end
        checks++; if (global_read_dependencies !== '0) begin failures++; $display("FAIL same_slot_grd got=%h exp=0", global_read_dependencies); end
        batch_completed = 1; batch_id = 4'd3;
        edge_step();
        drive_idle();
        checks++; if (global_write_dependencies !== '0) begin failures++; $display("FAIL retire_gwr got=%h exp=0", global_write_dependencies); end
    endtask

    task automatic test_reset_mid();
        new_batch_valid = 1; new_batch_id = 4'd0; new_batch_write_deps = 256'hF0; new_batch_owner_id = 64'd1;
        edge_step();
        drive_idle();
        txn_valid = 1; txn_write_deps = 256'hF0; txn_owner_id = 64'd2;
        #1;
        checks++; if (has_conflict !== 1'b1) begin failures++; $display("FAIL pre_reset_conflict got=%b exp=1", has_conflict); end
        edge_step();
        #2 rst = 1;
        model_reset();
        #1;
        checks++; if (has_conflict !== 1'b0 || conflict_type !== 3'b000) begin failures++; $display("FAIL mid_reset_conflict got=%b/%b exp=0/000", has_conflict, conflict_type); end
        checks++; if (global_write_dependencies !== '0) begin failures++; $display("FAIL mid_reset_gwr got=%h exp=0", global_write_dependencies); end
        checks++; if (global_conflicts !== 32'd0 || waw_conflict_count !== 32'd0) begin failures++; $display("FAIL mid_reset_counters got=%0d/%0d exp=0/0", global_conflicts, waw_conflict_count); end
        @(posedge clk);
        #1 rst = 0;
        #1;
        checks++; if (has_conflict !== 1'b0) begin failures++; $display("FAIL post_reset_conflict got=%b exp=0", has_conflict); end
        edge_step();
        checks++; if (global_conflicts !== 32'd0) begin failures++; $display("FAIL post_reset_counter got=%0d exp=0", global_conflicts); end
        drive_idle();
    endtask

    function automatic logic [D-1:0] rnd_deps();
        logic [D-1:0] v = '0;
        v[15:0] = 16'($urandom) & 16'($urandom);
        v[D-1]  = ($urandom_range(0, 7) == 0);
        return v;
    endfunction

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            txn_valid            = ($urandom_range(0, 3) != 0);
            txn_read_deps        = rnd_deps();
            txn_write_deps       = rnd_deps();
            txn_owner_id         = 64'($urandom_range(0, 3));
            new_batch_valid      = ($urandom_range(0, 2) == 0);
            new_batch_id         = 4'($urandom_range(0, 15));
            new_batch_read_deps  = rnd_deps();
            new_batch_write_deps = rnd_deps();
            new_batch_owner_id   = 64'($urandom_range(0, 3));
            batch_completed      = ($urandom_range(0, 2) == 0);
            batch_id             = ($urandom_range(0, 3) == 0) ? new_batch_id : 4'($urandom_range(0, 15));
            #1;
            checks++; if (conflict_type !== exp_type() || has_conflict !== (exp_type() != 3'b000)) begin
                failures++; $display("FAIL rand_conflict[%0d] got=%b/%b exp=%b", n, has_conflict, conflict_type, exp_type()); end
            edge_step();
            checks++; if (global_read_dependencies !== exp_grd() || global_write_dependencies !== exp_gwr()) begin
                failures++; $display("FAIL rand_global_deps[%0d] got=%h/%h exp=%h/%h", n, global_read_dependencies, global_write_dependencies, exp_grd(), exp_gwr()); end
            checks++; if ({global_conflicts, raw_conflict_count, waw_conflict_count, war_conflict_count} !== {m_gc, m_raw, m_waw, m_war}) begin
                failures++; $display("FAIL rand_counters[%0d] got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", n, global_conflicts, raw_conflict_count, waw_conflict_count, war_conflict_count, m_gc, m_raw, m_waw, m_war); end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_all_types();
        test_owner_exclusion();
        test_same_slot();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conflict_manager.md
CONFLICT_MANAGER -- requirements
Module: conflict_manager

Interface
REQ-001 SHALL have parameter MAX_DEPENDENCIES, default 256: width of the read/write dependency bit-vectors.
REQ-002 SHALL have parameter MAX_BATCHES, default 16: number of batch slots (at most 16, since batch IDs are 4 bits).
REQ-003 Ports SHALL be, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- txn_valid  in  1  candidate transaction present.
- txn_read_deps  in  MAX_DEPENDENCIES  candidate read set.
- txn_write_deps  in  MAX_DEPENDENCIES  candidate write set.
- txn_owner_id  in  64  candidate owner/program ID.
- has_conflict  out  1  candidate conflicts with an active batch.
- conflict_type  out  3  [2]=RAW, [1]=WAW, [0]=WAR.
- new_batch_valid  in  1  register a new batch this cycle.
- new_batch_id  in  4  slot index for the new batch.
- new_batch_read_deps  in  MAX_DEPENDENCIES  batch read-set union.
- new_batch_write_deps  in  MAX_DEPENDENCIES  batch write-set union.
- new_batch_owner_id  in  64  batch owner ID.
- batch_completed  in  1  retire a batch this cycle.
- batch_id  in  4  slot index to retire.
- global_read_dependencies  out  MAX_DEPENDENCIES  OR of the read sets of all active slots.
- global_write_dependencies  out  MAX_DEPENDENCIES  OR of the write sets of all active slots.
- global_conflicts  out  32  total conflict events.
- raw_conflict_count  out  32  RAW events.
- waw_conflict_count  out  32  WAW events.
- war_conflict_count  out  32  WAR events.

Function
REQ-004 SHALL hold MAX_BATCHES slots, each storing: valid bit, read set, write set, 64-bit owner.
REQ-005 On a clk edge with new_batch_valid=1 and new_batch_id<MAX_BATCHES, SHALL write the batch's sets and owner into slot[new_batch_id] and set it valid.
- An occupied slot is overwritten.
REQ-006 On a clk edge with batch_completed=1 and batch_id<MAX_BATCHES, SHALL clear slot[batch_id].valid.
- Clearing an already-invalid slot is a no-op.
REQ-007 When registration and completion target the same slot in the same cycle, registration SHALL win: the slot ends valid with the new data.
REQ-008 Out-of-range IDs (>=MAX_BATCHES) SHALL be ignored.
REQ-009 global_read_dependencies and global_write_dependencies SHALL be combinational ORs over valid slots only.
- Changes are visible the cycle after the registering or retiring edge.
- Both are all-zero when no slot is valid.
REQ-010 Conflict evaluation SHALL be combinational against the registered table, excluding any valid slot whose owner equals txn_owner_id. Let R and W be the OR of read and write sets over the remaining valid slots.
REQ-011 conflict_type SHALL be computed as follows; all bits SHALL be 0 when txn_valid=0:
- RAW = |(txn_read_deps & W)
- WAW = |(txn_write_deps & W)
- WAR = |(txn_write_deps & R)
REQ-012 has_conflict SHALL be the OR of the conflict_type bits; it is 0 when txn_valid=0 or when both candidate sets are zero.
REQ-013 A batch registered in cycle N SHALL NOT affect has_conflict in cycle N; it is seen from cycle N+1.
REQ-014 Counter updates SHALL occur on every clk edge with has_conflict=1:
- global_conflicts +1.
- Each asserted conflict_type bit +1 on its own counter; several may increment together.
- Counting is per cycle, so a candidate held for k cycles counts k times.
REQ-015 Counters SHALL wrap modulo 2^32.

Reset
REQ-016 While rst=1, asynchronously and regardless of clk:
- all slot valid bits SHALL be 0, and stored sets and owners SHALL be 0;
- all four counters SHALL be 0;
- consequently global_* deps, has_conflict and conflict_type SHALL read 0.
REQ-017 Reset asserted mid-operation SHALL discard all active batches; the first edge after rst deasserts SHALL operate normally.

Structure
REQ-018 A shared package SHALL hold:
- the conflict_type bit indices (RAW=2, WAW=1, WAR=0);
- the batch-ID width (4) and owner-ID width (64);
- a slot-record typedef {valid, read set, write set, owner}.
REQ-019 The OR-reduction with owner exclusion SHALL be one sub-module, dep_union_reduce, instantiated twice: once unmasked for the global outputs, once owner-masked for conflict evaluation.

Verification
REQ-020 Bench SHALL cover:
- Reset, then txn_valid=1, read=0x1, write=0x2 -> has_conflict=0, conflict_type=000, all counters 0.
- Register slot 3: read=0x0F, write=0xF0, owner=5. Next cycle:
  - txn read=0x10, write=0, owner=9 -> RAW only; conflict_type=100; after the edge global_conflicts=1, raw_conflict_count=1.
  - txn write=0x11, owner=9 -> conflict_type=111; raw, waw and war counters each +1.
- Same table, txn owner=5 with read=0x10 -> has_conflict=0 (owner exclusion); global_write_dependencies=0xF0 still.
- batch_completed with batch_id=3 together with new_batch_valid id=3 write=0x100 -> next cycle global_write_dependencies=0x100, global_read_dependencies=0.
- Slot 0 active, assert rst mid-cycle -> outputs zero immediately; after release, txn write=0xF0 -> no conflict.
